// File: rtl/demux_pkg.sv
// Shared types and helpers for the slot demux / word deserialiser.
//   demux_mode_t : word fill mode, latched on the first beat of each word
//   slot_lsb     : bit offset of slot k when each slot is w bits wide
package demux_pkg;

    typedef enum logic {
        MODE_SEQ  = 1'b0,
        MODE_ADDR = 1'b1
    } demux_mode_t;

    function automatic int slot_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/word_out_reg.sv
// Valid/ready holding register for one completed word.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load, load_data     : offer a word; only honoured while free=1
//   ready               : downstream ready
//   valid, data         : registered word and its valid flag
//   free                : register can take a word on this edge
//                         (empty, or draining on this edge)
module word_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (free) begin
            // Drain and reload share one edge, so back-to-back words need no bubble.
            valid <= load;
            if (load) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/demux_slot_deser.sv
// Registered symbol-to-word deserialiser. Symbols of DATA_W bits are steered
// into N_SLOTS slots of an assembly word, either sequentially (auto pointer)
// or by explicit slot select, and completed words are handed to a
// valid/ready output register with backpressure to the symbol source.
// Ports:
//   inClk, inResetN     : clock, asynchronous active-low reset
//   inValid, outAccept  : upstream handshake (beat taken on inValid & outAccept)
//   inData, inSel       : symbol and target slot (inSel used in addressed mode)
//   inMode, inLast      : 0 sequential / 1 addressed; inLast ends an addressed word
//   inFlush             : discard the word under assembly (and any held word)
//   outReady, outValid  : downstream handshake
//   outData, outMask    : completed word (slot 0 in LSBs) and written-slot mask
//   outErr              : sticky protocol error (mode mismatch, bad slot select)
module demux_slot_deser
    import demux_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int N_SLOTS = 8,
    parameter int SEL_W   = $clog2(N_SLOTS)
) (
    input  logic                      inClk,
    input  logic                      inResetN,
    input  logic                      inValid,
    input  logic [DATA_W-1:0]         inData,
    input  logic [SEL_W-1:0]          inSel,
    input  logic                      inMode,
    input  logic                      inLast,
    input  logic                      inFlush,
    input  logic                      outReady,
    output logic                      outAccept,
    output logic [N_SLOTS*DATA_W-1:0] outData,
    output logic [N_SLOTS-1:0]        outMask,
    output logic                      outValid,
    output logic                      outErr
);

    localparam int WORD_W = N_SLOTS * DATA_W;

    logic [WORD_W-1:0]  asm_q, asm_n, beat_word, load_word;
    logic [N_SLOTS-1:0] mask_q, mask_n, beat_mask, load_mask;
    logic [SEL_W-1:0]   ptr_q, ptr_n;
    logic               pending_q, pending_n;
    demux_mode_t        mode_q, mode_n, beat_mode;
    logic               err_q, err_n;
    logic               accept, first_beat, beat_done, load, out_free;
    logic [N_SLOTS+WORD_W-1:0] out_bus;

    // A held word blocks new beats; reset forces the handshake low too.
    assign outAccept  = inResetN & ~pending_q;
    assign accept     = inValid & outAccept;
    assign first_beat = (mask_q == '0);
    assign beat_mode  = first_beat ? demux_mode_t'(inMode) : mode_q;
    assign outErr     = err_q;

    always_comb begin
        asm_n     = asm_q;
        mask_n    = mask_q;
        ptr_n     = ptr_q;
        pending_n = pending_q;
        mode_n    = mode_q;
        err_n     = err_q;
        beat_word = asm_q;
        beat_mask = mask_q;
        beat_done = 1'b0;
        load      = 1'b0;
        load_word = asm_q;
        load_mask = mask_q;

        if (inFlush) begin
            // Flush wins over everything, including a beat in the same cycle
            // and a held word that could otherwise transfer now.
            asm_n     = '0;
            mask_n    = '0;
            ptr_n     = '0;
            pending_n = 1'b0;
            mode_n    = MODE_SEQ;
        end else if (pending_q) begin
            if (out_free) begin
                load      = 1'b1;
                asm_n     = '0;
                mask_n    = '0;
                ptr_n     = '0;
                pending_n = 1'b0;
            end
        end else if (accept) begin
            if (!first_beat && (inMode != logic'(mode_q))) begin
                err_n = 1'b1;
            end else begin
                mode_n = beat_mode;
                if (beat_mode == MODE_SEQ) begin
                    beat_word[slot_lsb(int'(ptr_q), DATA_W) +: DATA_W] = inData;
                    beat_mask[ptr_q] = 1'b1;
                    if (ptr_q == SEL_W'(N_SLOTS - 1)) begin
                        beat_done = 1'b1;
                        ptr_n     = '0;
                    end else begin
                        ptr_n = ptr_q + SEL_W'(1);
                    end
                end else begin
                    if (int'(inSel) < N_SLOTS) begin
                        beat_word[slot_lsb(int'(inSel), DATA_W) +: DATA_W] = inData;
                        beat_mask[inSel] = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    beat_done = inLast;
                end

                asm_n  = beat_word;
                mask_n = beat_mask;
                if (beat_done) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_word = beat_word;
                        load_mask = beat_mask;
                        asm_n     = '0;
                        mask_n    = '0;
                        ptr_n     = '0;
                    end else begin
                        pending_n = 1'b1;
                    end
                end
            end
        end
    end

    // Assembly state
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            asm_q     <= '0;
            mask_q    <= '0;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            mode_q    <= MODE_SEQ;
            err_q     <= 1'b0;
        end else begin
            asm_q     <= asm_n;
            mask_q    <= mask_n;
            ptr_q     <= ptr_n;
            pending_q <= pending_n;
            mode_q    <= mode_n;
            err_q     <= err_n;
        end
    end

    // Output stage
    word_out_reg #(
        .W(N_SLOTS + WORD_W)
    ) u_word_out_reg (
        .clk       (inClk),
        .rst_n     (inResetN),
        .load      (load),
        .load_data ({load_mask, load_word}),
        .ready     (outReady),
        .valid     (outValid),
        .data      (out_bus),
        .free      (out_free)
    );

    assign outData = out_bus[WORD_W-1:0];
    assign outMask = out_bus[N_SLOTS+WORD_W-1:WORD_W];

endmodule

// File: tb/tb_demux_slot_deser.sv
module tb_demux_slot_deser;

    localparam int DATA_W  = 4;
    localparam int N_SLOTS = 8;
    localparam int SEL_W   = $clog2(N_SLOTS);

    logic                      inClk = 1'b0;
    logic                      inResetN;
    logic                      inValid;
    logic [DATA_W-1:0]         inData;
    logic [SEL_W-1:0]          inSel;
    logic                      inMode;
    logic                      inLast;
    logic                      inFlush;
    logic                      outReady;
    logic                      outAccept;
    logic [N_SLOTS*DATA_W-1:0] outData;
    logic [N_SLOTS-1:0]        outMask;
    logic                      outValid;
    logic                      outErr;

    int n_cmp  = 0;
    int n_fail = 0;

    demux_slot_deser #(
        .DATA_W (DATA_W),
        .N_SLOTS(N_SLOTS)
    ) dut (
        .inClk    (inClk),
        .inResetN (inResetN),
        .inValid  (inValid),
        .inData   (inData),
        .inSel    (inSel),
        .inMode   (inMode),
        .inLast   (inLast),
        .inFlush  (inFlush),
        .outReady (outReady),
        .outAccept(outAccept),
        .outData  (outData),
        .outMask  (outMask),
        .outValid (outValid),
        .outErr   (outErr)
    );

    always #5 inClk = ~inClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge with inValid low.
    task automatic beat(input logic [3:0] d, input logic m, input logic [2:0] s, input logic l);
        inValid = 1'b1;
        inData  = d;
        inMode  = m;
        inSel   = s;
        inLast  = l;
        @(posedge inClk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic idle();
        @(posedge inClk);
        #1;
    endtask

    initial begin
        inResetN = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inSel    = '0;
        inMode   = 1'b0;
        inLast   = 1'b0;
        inFlush  = 1'b0;
        outReady = 1'b1;

        // Reset state
        idle();
        idle();
        check("rst_valid",  outValid,  0);
        check("rst_data",   outData,   0);
        check("rst_mask",   outMask,   0);
        check("rst_err",    outErr,    0);
        check("rst_accept", outAccept, 0);
        inResetN = 1'b1;
        #1;
        check("rel_accept", outAccept, 1);

        // 1. Sequential fill, beats 1..8
        for (int i = 1; i <= 7; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t1_not_yet", outValid, 0);
        beat(4'h8, 1'b0, 3'd0, 1'b0);
        check("t1_valid", outValid, 1);
        check("t1_data",  outData,  32'h87654321);
        check("t1_mask",  outMask,  8'hFF);
        idle();
        check("t1_one_cycle", outValid, 0);

        // 2. Addressed writes
        beat(4'hA, 1'b1, 3'd5, 1'b0);
        check("t2_not_yet", outValid, 0);
        beat(4'h3, 1'b1, 3'd2, 1'b1);
        check("t2_valid", outValid, 1);
        check("t2_data",  outData,  32'h00A00300);
        check("t2_mask",  outMask,  8'h24);
        idle();
        check("t2_drained", outValid, 0);

        // 3. Backpressure: two words with downstream stalled
        outReady = 1'b0;
        for (int i = 1; i <= 8; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t3_w1_valid", outValid, 1);
        check("t3_w1_accept", outAccept, 1);
        for (int i = 9; i <= 16; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t3_blocked", outAccept, 0);
        check("t3_w1_held", outData, 32'h87654321);
        beat(4'h5, 1'b0, 3'd0, 1'b0);
        check("t3_still_blocked", outAccept, 0);
        check("t3_w1_stable", outData, 32'h87654321);
        check("t3_w1_valid2", outValid, 1);
        outReady = 1'b1;
        idle();
        check("t3_w2_valid",  outValid,  1);
        check("t3_w2_data",   outData,   32'h0FEDCBA9);
        check("t3_w2_mask",   outMask,   8'hFF);
        check("t3_accept_back", outAccept, 1);
        idle();
        check("t3_w2_once", outValid, 0);

        // 4. Flush mid-word; a beat in the flush cycle is dropped too
        beat(4'h1, 1'b0, 3'd0, 1'b0);
        beat(4'h2, 1'b0, 3'd0, 1'b0);
        beat(4'h3, 1'b0, 3'd0, 1'b0);
        inFlush = 1'b1;
        beat(4'h7, 1'b0, 3'd0, 1'b0);
        inFlush = 1'b0;
        check("t4_flush_noout", outValid, 0);
        for (int i = 15; i >= 9; i--) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t4_not_yet", outValid, 0);
        beat(4'h8, 1'b0, 3'd0, 1'b0);
        check("t4_valid", outValid, 1);
        check("t4_data",  outData,  32'h89ABCDEF);
        check("t4_mask",  outMask,  8'hFF);
        idle();
        check("t4_single", outValid, 0);

        // 6. Mode mismatch: dropped beat, sticky error, pointer unaffected
        beat(4'h1, 1'b0, 3'd0, 1'b0);
        beat(4'hE, 1'b1, 3'd0, 1'b0);
        check("t6_err", outErr, 1);
        for (int i = 2; i <= 8; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t6_valid", outValid, 1);
        check("t6_data",  outData,  32'h87654321);
        check("t6_sticky", outErr, 1);
        idle();

        // 5. Asynchronous reset mid-word with a held output word
        outReady = 1'b0;
        for (int i = 1; i <= 8; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        beat(4'hA, 1'b0, 3'd0, 1'b0);
        beat(4'hB, 1'b0, 3'd0, 1'b0);
        check("t5_pre_valid", outValid, 1);
        #3;
        inResetN = 1'b0;
        #1;
        check("t5_valid",  outValid,  0);
        check("t5_data",   outData,   0);
        check("t5_mask",   outMask,   0);
        check("t5_err",    outErr,    0);
        check("t5_accept", outAccept, 0);
        idle();
        inResetN = 1'b1;
        outReady = 1'b1;
        #1;
        check("t5_rel_accept", outAccept, 1);
        for (int i = 2; i <= 9; i++) beat(4'(i), 1'b0, 3'd0, 1'b0);
        check("t5_word_valid", outValid, 1);
        check("t5_word_data",  outData,  32'h98765432);
        check("t5_word_mask",  outMask,  8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_slot_deser.md
Name: demux_slot_deser

Overview:
Parametrised, registered successor to the combinational 1:8 nibble demux. Input symbols of DATA_W bits are steered into one of N_SLOTS slots of an assembly word, either by explicit slot select or by auto-incrementing pointer. A completed word is handed to a valid/ready output register, with backpressure to the upstream symbol source. It sits between the symbol/chip stage and the word-level consumers in the ZigBee datapath.

Parameters:
DATA_W, 4, width of one slot/input symbol
N_SLOTS, 8, slots per output word; at least 2, need not be a power of 2
SEL_W, $clog2(N_SLOTS), slot-select width (derived; do not override)

Ports:
inClk  input  1  sole clock; all state on rising edge
inResetN  input  1  asynchronous, active-low reset
inValid  input  1  upstream beat valid
inData  input  DATA_W  symbol to write
inSel  input  SEL_W  target slot (addressed mode only)
inMode  input  1  0 = sequential fill, 1 = addressed write
inLast  input  1  addressed mode: this beat completes the word
inFlush  input  1  discard the word in assembly
outReady  input  1  downstream ready
outAccept  output  1  upstream ready; a beat is accepted when inValid & outAccept
outData  output  N_SLOTS*DATA_W  completed word; slot k at bits [k*DATA_W +: DATA_W]
outMask  output  N_SLOTS  slots written in outData
outValid  output  1  outData/outMask valid
outErr  output  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release): assembly, mask, pointer, pending flag, outData, outMask, outValid and outErr all 0. outAccept = inResetN & !pending, so it reads 0 during reset and 1 after release.
- Slot mapping: slot 0 occupies the LSBs. inData bit order is preserved within a slot. Unwritten slots read 0.
- Mode latching: the word mode is latched from inMode on the first accepted beat of a word (mask==0).
  - If a later beat's inMode differs from the latched mode, the beat is dropped and outErr is set.
- Sequential mode: each accepted beat writes slot ptr, then ptr increments. The beat with ptr==N_SLOTS-1 completes the word; ptr wraps to 0. inSel and inLast are ignored.
- Addressed mode: each accepted beat writes slot inSel and sets that mask bit. Rewriting a slot overwrites it (last write wins). A beat with inLast=1 completes the word, including that beat.
  - inSel >= N_SLOTS: write dropped, outErr set. inLast on such a beat still completes the word.
- Completion transfer: the completed word moves into the output register on the completing edge if the output register is empty, or if outValid & outReady in that cycle. outValid is then 1 in the next cycle, giving 1-cycle latency. Assembly and mask clear to 0.
  - Otherwise the word is held in assembly with pending=1, so outAccept=0. It transfers on the first edge where the output register frees, and pending then clears.
- Output register: outValid stays 1 and outData/outMask stay stable until outValid & outReady. A new word can load in the same cycle as the drain (full throughput, no bubble).
- inFlush: on that edge, assembly, mask, pointer, latched mode and pending are cleared, and any held word is discarded. A beat accepted in the same cycle is dropped. The output register is unaffected.
- outErr clears only on reset.
- No combinational path from inValid/inData to outputs. outAccept depends only on registered state and reset.

Decomposition:
- Package demux_pkg:
  - typedef enum logic {MODE_SEQ, MODE_ADDR} demux_mode_t
  - slot_lsb(k, w) function returning k*w
- One sub-module, word_out_reg: a parametrised-width valid/ready holding register (load, drain, simultaneous load+drain). It is instantiated once for {outMask, outData}.

Test Plan:
1. DATA_W=4, N_SLOTS=8, sequential mode, outReady=1, beats 0x1..0x8 -> one cycle after the 8th beat: outData=0x87654321, outMask=0xFF, outValid=1 for exactly one cycle.
2. Addressed mode: (sel=5, data=0xA), then (sel=2, data=0x3, inLast=1) -> outData=0x00A00300, outMask=0x24.
3. outReady=0, two full sequential words -> after word 2 completes, outAccept=0 and word 1 is held. Set outReady=1 -> word 1 drains, word 2 appears next cycle, outAccept returns to 1, no data lost or duplicated.
4. 3 sequential beats, then inFlush, then 8 beats 0xF..0x8 -> a single output word 0x89ABCDEF; the flushed beats never appear.
5. Assert inResetN low asynchronously mid-word, with outValid=1 -> all outputs 0 immediately. After release, the first word starts at slot 0.
6. Mode mismatch: start in sequential mode, send one beat with inMode=1 -> beat dropped, outErr=1 and sticky. The next sequential beats continue from the correct slot.
